// File: rtl/sram_ctrl_burst_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_burst_if
// Brief    : MEM-stage request/response bundle for the burst SRAM controller.
// Revision : 1.0
// ============================================================================
interface sram_ctrl_burst_if #(
    parameter int DATA_W = 32
);
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              ready;
    logic              err;

    modport master (output wr_en, rd_en, address, writeData, input readData, ready, err);
    modport slave  (input wr_en, rd_en, address, writeData, output readData, ready, err);
endinterface
`default_nettype wire

// File: rtl/sram_ctrl_burst.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_burst
// Brief    : Maps one DATA_W-bit MEM-stage access onto DATA_W/16 beats of a
//            16-bit asynchronous SRAM, with range checking and pipeline stall.
// Revision : 1.0
// ============================================================================
module sram_ctrl_burst #(
    parameter int DATA_W      = 32,
    parameter int SRAM_AW     = 18,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sram_ctrl_burst_if.slave   bus,
    inout  wire [15:0]         SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);
    localparam int                 c_beats     = DATA_W / 16;
    localparam int                 c_beat_w    = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int                 c_addr_lsb  = $clog2(DATA_W / 8);
    localparam logic [3:0]         c_last_act  = 4'(WAIT_CYCLES);
    localparam logic [3:0]         c_last_cyc  = 4'(WAIT_CYCLES + 1);
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);
    localparam logic [c_beat_w-1:0] c_beat_one  = 1;
    localparam logic [SRAM_AW-1:0] c_addr_one  = 1;
    localparam logic [31:0]        c_base      = BASE_ADDR;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_beat_w-1:0] r_beat, w_beat_nxt;
    logic [3:0]          r_cyc, w_cyc_nxt;
    logic                r_is_wr, r_err;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic [SRAM_AW-1:0]  r_sram_addr;
    logic                r_ce_n, r_ub_n, r_lb_n, r_we_n, r_oe_n;

    logic                w_req, w_is_wr_nxt, w_active_nxt, w_range_err;
    logic [31:0]         w_off;
    logic [39:0]         w_first, w_last;
    logic [c_beat_w+3:0] w_lane;

    assign w_req = bus.wr_en | bus.rd_en;

    // Wide arithmetic so a huge index cannot wrap back into range.
    assign w_off       = bus.address - c_base;
    assign w_first     = 40'(w_off >> c_addr_lsb) * 40'(c_beats);
    assign w_last      = w_first + 40'(c_beats - 1);
    assign w_range_err = (bus.address < c_base) || (w_last >= (40'd1 << SRAM_AW));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_cyc   <= w_cyc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_cyc_nxt   = r_cyc;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_beat_nxt  = '0;
                    w_cyc_nxt   = '0;
                    w_state_nxt = w_range_err ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cyc == c_last_cyc) begin
                    w_cyc_nxt = '0;
                    if (r_beat == c_last_beat) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_beat_nxt = r_beat + c_beat_one;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 4'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered, so they are computed from the upcoming cycle.
    assign w_is_wr_nxt  = (r_state == S_IDLE) ? bus.wr_en : r_is_wr;
    assign w_active_nxt = (w_state_nxt == S_ACCESS) && (w_cyc_nxt <= c_last_act);
    assign w_lane       = {r_beat, 4'h0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_wr     <= 1'b0;
            r_err       <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
            r_ce_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
        end else begin
            if ((r_state == S_IDLE) && w_req) begin
                r_is_wr <= bus.wr_en;
                r_err   <= w_range_err;
                r_wdata <= bus.writeData;
            end
            // Address moves only when entering cycle 0 of a beat, never under WE_N low.
            if ((r_state == S_IDLE) && (w_state_nxt == S_ACCESS)) begin
                r_sram_addr <= w_first[SRAM_AW-1:0];
            end else if ((r_state == S_ACCESS) && (w_state_nxt == S_ACCESS) && (w_cyc_nxt == 4'd0)) begin
                r_sram_addr <= r_sram_addr + c_addr_one;
            end
            r_ce_n <= !w_active_nxt;
            r_ub_n <= !w_active_nxt;
            r_lb_n <= !w_active_nxt;
            r_we_n <= !(w_active_nxt && w_is_wr_nxt);
            r_oe_n <= !(w_active_nxt && !w_is_wr_nxt);
            if ((r_state == S_ACCESS) && !r_is_wr && (r_cyc == c_last_act)) begin
                r_rdata[w_lane +: 16] <= SRAM_DQ;
            end
        end
    end

    assign SRAM_DQ   = ((r_state == S_ACCESS) && r_is_wr) ? r_wdata[w_lane +: 16] : 16'hzzzz;
    assign SRAM_ADDR = r_sram_addr;
    assign SRAM_CE_N = r_ce_n;
    assign SRAM_UB_N = r_ub_n;
    assign SRAM_LB_N = r_lb_n;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_OE_N = r_oe_n;

    assign bus.readData = r_rdata;
    assign bus.err      = (r_state == S_DONE) && r_err;
    assign bus.ready    = (r_state == S_IDLE) ? !w_req : (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl_burst.sv
`timescale 1ns/1ps
// Randomized bench for sram_ctrl_burst: default instance against a behavioural
// memory model, plus a 64-bit zero-wait instance for the parameter sweep.
module tb_sram_ctrl_burst;
    localparam int DW = 32, AW = 18, BASE = 1024, WC = 1, NB = DW / 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    sram_ctrl_burst_if #(.DATA_W(DW)) bus ();
    wire [15:0]     dq;
    logic [AW-1:0]  sa;
    logic           ub_n, lb_n, we_n, ce_n, oe_n;

    sram_ctrl_burst #(.DATA_W(DW), .SRAM_AW(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq), .SRAM_ADDR(sa),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n));

    sram_ctrl_burst_if #(.DATA_W(64)) bus2 ();
    wire [15:0]     dq2;
    logic [AW-1:0]  sa2;
    logic           ub2_n, lb2_n, we2_n, ce2_n, oe2_n;

    sram_ctrl_burst #(.DATA_W(64), .SRAM_AW(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut64 (
        .clk(clk), .rst(rst), .bus(bus2), .SRAM_DQ(dq2), .SRAM_ADDR(sa2),
        .SRAM_UB_N(ub2_n), .SRAM_LB_N(lb2_n), .SRAM_WE_N(we2_n), .SRAM_CE_N(ce2_n), .SRAM_OE_N(oe2_n));

    // Board SRAM models: drive on read strobes, store at the clock while WE_N is low.
    logic [15:0] sram_mem  [0:(1<<AW)-1];
    logic [15:0] sram_mem2 [0:(1<<AW)-1];
    assign dq  = (!ce_n  && !oe_n  && we_n)  ? sram_mem[sa]   : 16'hzzzz;
    assign dq2 = (!ce2_n && !oe2_n && we2_n) ? sram_mem2[sa2] : 16'hzzzz;
    always @(posedge clk) if (!ce_n  && !we_n)  sram_mem[sa]   <= dq;
    always @(posedge clk) if (!ce2_n && !we2_n) sram_mem2[sa2] <= dq2;

    // Reference contents of the SRAM as the processor should see it.
    logic [15:0] ref_mem [int];
    logic [DW-1:0] exp_rdata = '0;

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_txn(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [DW-1:0] wd, input bit keep, input int drop_at);
        longint        a, idx;
        bit            oor, is_wr, conflict, moved, lane_bad;
        int            lat, act_cnt, exp_lat;
        logic [AW-1:0] qa[$];
        logic [15:0]   qd[$];
        logic [AW-1:0] prev_a;
        logic          prev_we;
        a     = addr;
        is_wr = wr;
        oor   = (a < BASE);
        idx   = oor ? 0 : (a - BASE) / (DW / 8);
        if (!oor && (idx * NB + NB - 1 >= (longint'(1) << AW))) oor = 1;
        exp_lat = oor ? 1 : 1 + NB * (WC + 2);

        @(negedge clk);
        bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.writeData = wd;
        #1;
        lat = 0; act_cnt = 0; conflict = 0; moved = 0; lane_bad = 0; prev_we = 1'b1; prev_a = '0;
        while (bus.ready === 1'b0 && lat < 200) begin
            lat++;
            if (!ce_n) act_cnt++;
            if (!we_n && !oe_n) conflict = 1;
            if (ub_n !== ce_n || lb_n !== ce_n) lane_bad = 1;
            if (!we_n) begin
                if (!prev_we && sa !== prev_a) moved = 1;
                qa.push_back(sa);
                qd.push_back(dq);
            end
            prev_we = we_n; prev_a = sa;
            if (lat == 2 && !keep) begin
                bus.address   = $urandom;
                bus.writeData = {$urandom};
            end
            if (drop_at != 0 && lat == drop_at) begin
                bus.wr_en = 1'b0; bus.rd_en = 1'b0;
            end
            @(negedge clk); #1;
        end

        check("latency", lat, exp_lat);
        check("err", bus.err, oor);
        check("strobe_cycles", act_cnt, oor ? 0 : NB * (WC + 1));
        check("oe_we_overlap", conflict, 0);
        check("addr_moved_under_we", moved, 0);
        check("ub_lb_follow_ce", lane_bad, 0);
        if (is_wr && !oor) begin
            check("write_cycles", qa.size(), NB * (WC + 1));
            for (int i = 0; i < qa.size() && i < NB * (WC + 1); i++) begin
                check("write_addr", qa[i], idx * NB + i / (WC + 1));
                check("write_data", qd[i], wd[16 * (i / (WC + 1)) +: 16]);
            end
            for (int k = 0; k < NB; k++) ref_mem[int'(idx * NB + k)] = wd[16 * k +: 16];
        end else begin
            check("no_write", qa.size(), 0);
            if (!oor) for (int k = 0; k < NB; k++) exp_rdata[16 * k +: 16] = ref_rd(int'(idx * NB + k));
        end
        check("readData", bus.readData, exp_rdata);
        if (!keep) begin
            bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        end
    endtask

    task automatic do_txn64(input logic wr, input logic [63:0] wd, input logic [63:0] exp_rd);
        int            lat;
        logic [AW-1:0] qa[$];
        logic [15:0]   qd[$];
        @(negedge clk);
        bus2.wr_en = wr; bus2.rd_en = !wr; bus2.address = 32'd1032; bus2.writeData = wd;
        #1;
        lat = 0;
        while (bus2.ready === 1'b0 && lat < 200) begin
            lat++;
            if (!we2_n) begin
                qa.push_back(sa2);
                qd.push_back(dq2);
            end
            @(negedge clk); #1;
        end
        check("latency64", lat, 9);
        if (wr) begin
            check("write_cycles64", qa.size(), 4);
            for (int k = 0; k < 4 && k < qa.size(); k++) begin
                check("write_addr64", qa[k], 4 + k);
                check("write_data64", qd[k], wd[16 * k +: 16]);
            end
        end else begin
            check("readData64", bus2.readData, exp_rd);
        end
        bus2.wr_en = 1'b0; bus2.rd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        logic        wr, rd;
        int          sel, drop;
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i]  = 16'h0000;
            sram_mem2[i] = 16'h0000;
        end
        bus.wr_en = 0;  bus.rd_en = 0;  bus.address = 0;  bus.writeData = '0;
        bus2.wr_en = 0; bus2.rd_en = 0; bus2.address = 0; bus2.writeData = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;

        check("reset_ready", bus.ready, 1);
        check("reset_strobes", {ce_n, ub_n, lb_n, we_n, oe_n}, 5'b11111);
        check("reset_addr", sa, 0);
        check("reset_readData", bus.readData, 0);
        check("reset_err", bus.err, 0);

        do_txn(1, 0, 32'd1032, 32'hDEADBEEF, 0, 0);
        do_txn(0, 1, 32'd1032, '0, 0, 0);
        check("readback_deadbeef", bus.readData, 32'hDEADBEEF);
        do_txn(0, 1, 32'd1020, '0, 0, 0);
        do_txn(1, 0, 32'd525312, 32'h12345678, 0, 0);
        do_txn(1, 0, 32'd525308, 32'hCAFEF00D, 0, 0);
        do_txn(0, 1, 32'd525308, '0, 0, 0);
        do_txn(1, 0, 32'd1040, 32'hA5A55A5A, 0, 2);
        do_txn(0, 1, 32'd1040, '0, 0, 0);
        do_txn(1, 1, 32'd1044, 32'h0BADC0DE, 0, 0);
        do_txn(0, 1, 32'd1044, '0, 0, 0);
        do_txn(1, 0, 32'd1048, 32'h13579BDF, 1, 0);
        do_txn(1, 0, 32'd1048, 32'h13579BDF, 1, 0);
        do_txn(1, 0, 32'd1048, 32'h13579BDF, 0, 0);

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = $urandom_range(0, BASE - 1);
            else if (sel == 1) addr = 32'd525312 + $urandom_range(0, 4000);
            else               addr = BASE + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
            sel  = $urandom_range(1, 3);
            wr   = sel[0];
            rd   = sel[1];
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : 0;
            do_txn(wr, rd, addr, {$urandom}, 0, drop);
        end

        // Asynchronous reset in the middle of beat 1 of a write.
        @(negedge clk);
        bus.wr_en = 1; bus.rd_en = 0; bus.address = BASE + 100 * 4; bus.writeData = {$urandom};
        #1;
        repeat (4) begin @(negedge clk); #1; end
        check("beat1_we_active", we_n, 0);
        check("beat1_addr", sa, 201);
        rst = 1'b1;
        bus.wr_en = 0;
        #1;
        check("rst_strobes", {ce_n, ub_n, lb_n, we_n, oe_n}, 5'b11111);
        check("rst_addr", sa, 0);
        check("rst_readData", bus.readData, 0);
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_idle_ready", bus.ready, 1);
        do_txn(0, 1, 32'd1032, '0, 0, 0);

        do_txn64(1, 64'h0123_4567_89AB_CDEF, '0);
        do_txn64(0, '0, 64'h0123_4567_89AB_CDEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_ctrl_burst.md
Name: sram_ctrl_burst

Overview:
Parametrised successor to the team's 16-bit SRAM controller. It maps one DATA_W-bit memory-stage read or write onto DATA_W/16 consecutive beats of the external 16-bit asynchronous SRAM. Each beat has a configurable number of wait cycles and a recovery cycle. The block sits between the MEM stage and the board SRAM, and its ready output freezes the pipeline. New capabilities over the fixed controller:
- any word width;
- latched requests that complete even if the request is dropped;
- address range checking with an error pulse.

Parameters:
DATA_W, 32, processor word width; multiple of 16, range 16..128; BEATS = DATA_W/16.
SRAM_AW, 18, SRAM word-address width.
BASE_ADDR, 1024, processor byte address that maps to SRAM word 0.
WAIT_CYCLES, 1, extra active cycles per beat (0..7); active cycles per beat = WAIT_CYCLES+1.

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request
rd_en  in  1  read request
address  in  32  processor byte address
writeData  in  DATA_W  write data
readData  out  DATA_W  read data; registered
ready  out  1  0 = stall the pipeline
err  out  1  one-cycle pulse; request was out of range
SRAM_DQ  inout  16  SRAM data bus
SRAM_ADDR  out  SRAM_AW  SRAM word address; registered
SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out  1 each  active-low strobes; registered

Behaviour:
- Reset (asynchronous; takes effect immediately, including mid-transaction):
  - state IDLE;
  - all strobes 1;
  - SRAM_DQ high-Z;
  - SRAM_ADDR 0, readData 0, err 0, counters 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - ready = !(wr_en | rd_en), combinational.
  - On a request, latch at the clock edge: op (write wins if both are high), address, writeData, range result. Then go to ACCESS, beat 0, cycle 0.
- Address mapping:
  - off = address - BASE_ADDR;
  - idx = off >> log2(DATA_W/8), with the low bits ignored;
  - beat k uses SRAM_ADDR = idx*BEATS + k.
  - Beat k carries data bits [16k+15:16k]; beat 0 is least significant.
- Range error: address < BASE_ADDR, or idx*BEATS + BEATS-1 >= 2^SRAM_AW. On error:
  - ACCESS is skipped; go directly to DONE;
  - no strobe asserts;
  - readData is unchanged;
  - err = 1 in DONE only.
- ACCESS, one beat = WAIT_CYCLES+2 cycles:
  - Active cycles 0..WAIT_CYCLES: CE_N = UB_N = LB_N = 0. For a write, WE_N = 0; for a read, OE_N = 0.
  - Recovery cycle (last): all strobes 1, SRAM_ADDR unchanged.
  - Reads: SRAM_DQ is captured into readData[16k+15:16k] at the edge ending the last active cycle.
  - Writes: SRAM_DQ is driven with the beat's halfword for the whole beat, including recovery. In every other cycle SRAM_DQ is high-Z.
  - SRAM_ADDR updates only at beat boundaries (entering cycle 0). It is never changed while WE_N = 0.
  - After the last beat's recovery cycle: go to DONE.
- ACCESS behaviour independent of inputs:
  - ready = 0 throughout.
  - Changes on wr_en, rd_en, address and writeData are ignored.
  - Deasserting the request does not abort; the transaction completes.
- DONE:
  - ready = 1 for exactly one cycle;
  - readData is valid (reads);
  - next state IDLE, unconditionally.
- Latency: ready is low for 1 + BEATS*(WAIT_CYCLES+2) cycles. With defaults that is 7 cycles; ready is high in the 8th.
- Back-to-back requests:
  - A request held high through DONE is treated as consumed by the pipeline.
  - The next request is sampled in the following IDLE cycle, so there is one idle gap of ready = 0.
- No request: the block remains in IDLE with ready = 1 and all strobes high.

Test Plan:
1. Write, DATA_W=32, WAIT=1: address=1032, writeData=0xDEADBEEF → SRAM_ADDR 4 with DQ 0xBEEF, then SRAM_ADDR 5 with DQ 0xDEAD. WE_N low for 2 cycles per beat. ready low 7 cycles, then high 1 cycle.
2. Read back the same address with an SRAM model → readData = 0xDEADBEEF in the DONE cycle. OE_N is never low while WE_N is low; DQ is never driven by the controller during the read.
3. Parameter sweep:
   - DATA_W=64, WAIT=0, address=1024+8 → beats at SRAM_ADDR 4..7, ready low 1+4*2 = 9 cycles;
   - DATA_W=16 → single beat.
4. Out of range:
   - address=1020 → err = 1 for 1 cycle, ready low 1 cycle, no strobe asserts, readData unchanged;
   - address beyond 2^SRAM_AW words → same response.
5. Robustness:
   - drop wr_en after 2 cycles of a write → both beats are still written and DONE is reached;
   - assert rst during beat 1 → all strobes go high and DQ goes high-Z in the same cycle (before the next edge); state IDLE.
6. Simultaneous wr_en = rd_en = 1 → write performed. Request held continuously → transactions separated by DONE + 1 IDLE cycle; SRAM_ADDR is never changed while WE_N = 0.
